// File: rtl/adc_sample_buffer_if.sv
// rtl/adc_sample_buffer_if.sv - capture and read-port signal bundle for adc_sample_buffer
interface adc_sample_buffer_if #(
  parameter int DATA_W = 12
);
  logic [DATA_W-1:0] sample;
  logic              sample_valid;
  logic              rd_req;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;

  modport master (
    output sample, sample_valid, rd_req,
    input  rd_data, rd_valid
  );

  modport slave (
    input  sample, sample_valid, rd_req,
    output rd_data, rd_valid
  );
endinterface

// File: rtl/adc_sample_buffer.sv
// rtl/adc_sample_buffer.sv - circular ADC capture buffer with window fault latch and read port
module adc_sample_buffer #(
  parameter int DATA_W      = 12,
  parameter int DEPTH       = 64,
  parameter int ADDR_W      = 6,
  parameter int FAULT_COUNT = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  adc_sample_buffer_if.slave   bus,
  input  logic                 arm,
  input  logic [DATA_W-1:0]    thresh_lo,
  input  logic [DATA_W-1:0]    thresh_hi,
  output logic [ADDR_W:0]      fill_count,
  output logic                 full,
  output logic                 empty,
  output logic                 capturing,
  output logic                 fault,
  output logic [DATA_W-1:0]    fault_sample
);

  typedef enum logic [1:0] {IDLE, CAPTURE, HOLD} state_t;

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);
  localparam logic [7:0]      FC       = 8'(FAULT_COUNT);

  state_t            state, state_next;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [7:0]        run_cnt;
  logic [DATA_W-1:0] rd_data_q;
  logic              rd_valid_q;

  logic              out_win, wr_en, rd_en, fault_hit, becomes_full;
  logic [ADDR_W:0]   fill_next;

  // arm wins over both a coincident write and a coincident read
  assign out_win      = (bus.sample < thresh_lo) || (bus.sample > thresh_hi);
  assign wr_en        = (state == CAPTURE) && bus.sample_valid && !arm;
  assign rd_en        = bus.rd_req && (fill_count != '0) && !arm;
  assign fault_hit    = wr_en && out_win && ((run_cnt + 8'd1) == FC);
  assign becomes_full = wr_en && !rd_en && (fill_count == FULL_CNT - 1'b1);

  assign bus.rd_data  = rd_data_q;
  assign bus.rd_valid = rd_valid_q;

  // next fill level from accepted write/read; equal traffic leaves it unchanged
  always_comb begin
    fill_next = fill_count;
    if (arm)
      fill_next = '0;
    else if (wr_en && !rd_en)
      fill_next = fill_count + 1'b1;
    else if (rd_en && !wr_en)
      fill_next = fill_count - 1'b1;
  end

  // next state: arm restarts capture, a full or faulting write freezes the buffer
  always_comb begin
    state_next = state;
    if (arm)
      state_next = CAPTURE;
    else if (state == CAPTURE && (fault_hit || becomes_full))
      state_next = HOLD;
  end

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // sample storage; contents are not reset
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= bus.sample;
  end

  // pointers, counters, fault latch, read port and registered status flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fill_count   <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      capturing    <= 1'b0;
      run_cnt      <= '0;
      fault        <= 1'b0;
      fault_sample <= '0;
      rd_data_q    <= '0;
      rd_valid_q   <= 1'b0;
    end else begin
      fill_count <= fill_next;
      full       <= (fill_next == FULL_CNT);
      empty      <= (fill_next == '0);
      capturing  <= (state_next == CAPTURE);
      rd_valid_q <= rd_en;
      if (arm) begin
        wr_ptr       <= '0;
        rd_ptr       <= '0;
        run_cnt      <= '0;
        fault        <= 1'b0;
        fault_sample <= '0;
      end else begin
        if (rd_en) begin
          rd_data_q <= mem[rd_ptr];
          rd_ptr    <= rd_ptr + 1'b1;
        end
        if (wr_en) begin
          wr_ptr <= wr_ptr + 1'b1;
          if (!out_win)
            run_cnt <= '0;
          else if (run_cnt != FC)
            run_cnt <= run_cnt + 8'd1;
        end
        if (fault_hit) begin
          fault        <= 1'b1;
          fault_sample <= bus.sample;
        end
      end
    end
  end

endmodule

// File: tb/tb_adc_sample_buffer.sv
// tb/tb_adc_sample_buffer.sv - self-checking bench for adc_sample_buffer
module tb_adc_sample_buffer;

  localparam int DATA_W = 12;
  localparam int ADDR_W = 6;

  logic              clk = 1'b0;
  logic              rst;
  logic              arm;
  logic [DATA_W-1:0] thresh_lo, thresh_hi;
  logic [ADDR_W:0]   fill_count;
  logic              full, empty, capturing, fault;
  logic [DATA_W-1:0] fault_sample;

  adc_sample_buffer_if #(.DATA_W(DATA_W)) bus ();

  adc_sample_buffer #(
    .DATA_W(DATA_W), .DEPTH(64), .ADDR_W(ADDR_W), .FAULT_COUNT(4)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus), .arm(arm),
    .thresh_lo(thresh_lo), .thresh_hi(thresh_hi),
    .fill_count(fill_count), .full(full), .empty(empty),
    .capturing(capturing), .fault(fault), .fault_sample(fault_sample)
  );

  always #10 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  logic [DATA_W-1:0] sb [$];
  logic [DATA_W-1:0] exp_d;

  task automatic do_arm();
    @(posedge clk); #1 arm = 1'b1;
    @(posedge clk); #1 arm = 1'b0;
    sb.delete();
  endtask

  task automatic push_sample(input logic [DATA_W-1:0] s, input bit stored);
    @(posedge clk); #1 bus.sample = s; bus.sample_valid = 1'b1;
    @(posedge clk); #1 bus.sample_valid = 1'b0;
    if (stored) sb.push_back(s);
  endtask

  task automatic drain(input string name, input int n);
    for (int i = 0; i <= n; i++) begin
      @(posedge clk); #1;
      if (i > 0) begin
        exp_d = (sb.size() > 0) ? sb.pop_front() : '0;
        vectors++;
        if (bus.rd_valid !== 1'b1 || bus.rd_data !== exp_d) begin
          miscompares++;
          $display("FAIL %s[%0d]: rd_valid=%b rd_data=%03h want valid=1 data=%03h", name, i - 1, bus.rd_valid, bus.rd_data, exp_d);
        end
      end
      bus.rd_req = (i < n);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; arm = 1'b0; bus.sample = '0; bus.sample_valid = 1'b0; bus.rd_req = 1'b0;
    thresh_lo = 12'h000; thresh_hi = 12'hFFF;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    vectors++;
    if ({fill_count, full, empty, capturing, fault, fault_sample, bus.rd_valid, bus.rd_data} !==
        {7'd0, 1'b0, 1'b1, 1'b0, 1'b0, 12'h000, 1'b0, 12'h000}) begin
      miscompares++;
      $display("FAIL reset: fill=%0d full=%b empty=%b cap=%b fault=%b fs=%03h rv=%b rd=%03h want 0 0 1 0 0 000 0 000",
               fill_count, full, empty, capturing, fault, fault_sample, bus.rd_valid, bus.rd_data);
    end
    push_sample(12'h0AA, 1'b0);
    vectors++;
    if (fill_count !== 7'd0) begin
      miscompares++; $display("FAIL idle_ignore: fill=%0d want 0", fill_count);
    end
  endtask

  task automatic test_fill();
    thresh_lo = 12'h000; thresh_hi = 12'hFFF;
    do_arm();
    vectors++;
    if (capturing !== 1'b1 || empty !== 1'b1) begin
      miscompares++; $display("FAIL arm: cap=%b empty=%b want 1 1", capturing, empty);
    end
    for (int i = 0; i < 64; i++) push_sample(12'(i), 1'b1);
    vectors++;
    if (full !== 1'b1 || fill_count !== 7'd64 || capturing !== 1'b0 || fault !== 1'b0) begin
      miscompares++;
      $display("FAIL full: full=%b fill=%0d cap=%b fault=%b want 1 64 0 0", full, fill_count, capturing, fault);
    end
    push_sample(12'h7FF, 1'b0);
    vectors++;
    if (fill_count !== 7'd64) begin
      miscompares++; $display("FAIL no_overwrite: fill=%0d want 64", fill_count);
    end
  endtask

  task automatic test_drain();
    drain("drain64", 64);
    vectors++;
    if (empty !== 1'b1 || fill_count !== 7'd0) begin
      miscompares++; $display("FAIL drain_empty: empty=%b fill=%0d want 1 0", empty, fill_count);
    end
    @(posedge clk); #1 bus.rd_req = 1'b1;
    @(posedge clk); #1 bus.rd_req = 1'b0;
    vectors++;
    if (bus.rd_valid !== 1'b0 || bus.rd_data !== 12'h03F) begin
      miscompares++; $display("FAIL read_empty: rv=%b rd=%03h want 0 03f", bus.rd_valid, bus.rd_data);
    end
  endtask

  task automatic test_fault();
    logic [DATA_W-1:0] seq [7];
    seq = '{12'h050, 12'h060, 12'h800, 12'hF00, 12'hF10, 12'hF20, 12'hF30};
    thresh_lo = 12'h100; thresh_hi = 12'hE00;
    do_arm();
    for (int i = 0; i < 7; i++) begin
      push_sample(seq[i], 1'b1);
      if (i == 5) begin
        vectors++;
        if (fault !== 1'b0) begin
          miscompares++; $display("FAIL fault_early: fault=%b want 0", fault);
        end
      end
    end
    vectors++;
    if (fault !== 1'b1 || fault_sample !== 12'hF30 || fill_count !== 7'd7 || capturing !== 1'b0) begin
      miscompares++;
      $display("FAIL fault: fault=%b fs=%03h fill=%0d cap=%b want 1 f30 7 0", fault, fault_sample, fill_count, capturing);
    end
    push_sample(12'h700, 1'b0);
    vectors++;
    if (fill_count !== 7'd7 || fault_sample !== 12'hF30) begin
      miscompares++; $display("FAIL fault_hold: fill=%0d fs=%03h want 7 f30", fill_count, fault_sample);
    end
    drain("fault_data", 7);
  endtask

  task automatic test_no_fault();
    logic [DATA_W-1:0] seq [7];
    seq = '{12'h050, 12'h050, 12'h050, 12'h500, 12'h050, 12'h050, 12'h050};
    thresh_lo = 12'h100; thresh_hi = 12'hE00;
    do_arm();
    vectors++;
    if (fault !== 1'b0 || fault_sample !== 12'h000) begin
      miscompares++; $display("FAIL arm_clear: fault=%b fs=%03h want 0 000", fault, fault_sample);
    end
    for (int i = 0; i < 7; i++) push_sample(seq[i], 1'b1);
    vectors++;
    if (fault !== 1'b0 || capturing !== 1'b1 || fill_count !== 7'd7) begin
      miscompares++; $display("FAIL run_reset: fault=%b cap=%b fill=%0d want 0 1 7", fault, capturing, fill_count);
    end
    drain("nofault_data", 7);
  endtask

  task automatic test_inverted_window();
    thresh_lo = 12'h800; thresh_hi = 12'h100;
    do_arm();
    for (int i = 0; i < 4; i++) push_sample(12'h400, 1'b1);
    vectors++;
    if (fault !== 1'b1 || fault_sample !== 12'h400 || capturing !== 1'b0) begin
      miscompares++; $display("FAIL inverted: fault=%b fs=%03h cap=%b want 1 400 0", fault, fault_sample, capturing);
    end
    drain("inverted_data", 4);
  endtask

  task automatic test_back_to_back();
    thresh_lo = 12'h000; thresh_hi = 12'hFFF;
    do_arm();
    for (int i = 0; i < 10; i++) push_sample(12'h200 + 12'(i), 1'b1);
    @(posedge clk); #1 bus.sample = 12'h2AA; bus.sample_valid = 1'b1; bus.rd_req = 1'b1;
    @(posedge clk); #1 bus.sample_valid = 1'b0; bus.rd_req = 1'b0;
    exp_d = sb.pop_front();
    sb.push_back(12'h2AA);
    vectors++;
    if (fill_count !== 7'd10 || bus.rd_valid !== 1'b1 || bus.rd_data !== exp_d) begin
      miscompares++;
      $display("FAIL rw_same: fill=%0d rv=%b rd=%03h want 10 1 %03h", fill_count, bus.rd_valid, bus.rd_data, exp_d);
    end
    drain("rw_rest", 10);
  endtask

  task automatic test_reset_mid();
    thresh_lo = 12'h000; thresh_hi = 12'hFFF;
    do_arm();
    for (int i = 0; i < 20; i++) push_sample(12'h300 + 12'(i), 1'b1);
    vectors++;
    if (fill_count !== 7'd20) begin
      miscompares++; $display("FAIL pre_rst: fill=%0d want 20", fill_count);
    end
    @(posedge clk); #1 bus.rd_req = 1'b1;
    @(posedge clk); #1 rst = 1'b1;
    #2;
    vectors++;
    if ({fill_count, full, empty, capturing, fault, bus.rd_valid, bus.rd_data} !==
        {7'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 12'h000}) begin
      miscompares++;
      $display("FAIL mid_rst: fill=%0d full=%b empty=%b cap=%b fault=%b rv=%b rd=%03h want 0 0 1 0 0 0 000",
               fill_count, full, empty, capturing, fault, bus.rd_valid, bus.rd_data);
    end
    @(posedge clk); #1 rst = 1'b0; bus.rd_req = 1'b0;
    sb.delete();
    @(posedge clk); #1 arm = 1'b1; bus.sample = 12'h123; bus.sample_valid = 1'b1;
    @(posedge clk); #1 arm = 1'b0; bus.sample_valid = 1'b0;
    vectors++;
    if (fill_count !== 7'd0 || capturing !== 1'b1 || empty !== 1'b1) begin
      miscompares++; $display("FAIL arm_discard: fill=%0d cap=%b empty=%b want 0 1 1", fill_count, capturing, empty);
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_fault();
    test_no_fault();
    test_inverted_window();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
